// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The state encoding and legal WIDTH range are used by serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder; ovf exists only when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/FullAdder1.sv
// One-bit full-adder cell: F is the sum bit, C1 the carry out.
module FullAdder1 (
    input  logic A,
    input  logic B,
    input  logic C0,
    output logic F,
    output logic C1
);

    assign F  = A ^ B ^ C0;
    assign C1 = (A & B) | (C0 & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder1 cell, registered carry, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             fa_f_s;
    logic             fa_c1_s;

    FullAdder1 u_fa (
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .C0 (carry_q),
        .F  (fa_f_s),
        .C1 (fa_c1_s)
    );

    // Next-state and datapath: sum/cout only change on the final shift.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                s_sh_d  = {fa_f_s, s_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_c1_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_f_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c1_s;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_c1_s;
`endif
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            s_sh_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vector table and corner sequences,
// plus an exhaustive WIDTH=4 instance.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic get_ovf8();
`ifdef SERIAL_ADDER_OVF_EN
        return bus8.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Launch one add on the 8-bit DUT, return result and busy width at the done cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co, output logic ov,
                        output int bw, output logic to);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
        bw = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus8.busy) bw++;
            if (bus8.done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        s = bus8.sum; co = bus8.cout; ov = get_ovf8();
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [3:0] s, output logic co, output int bw, output logic to);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
        @(negedge clk);
        bus4.start = 1'b0;
        bw = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus4.busy) bw++;
            if (bus4.done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        s = bus4.sum; co = bus4.cout;
    endtask

    initial begin
        logic [7:0] s8;
        logic [3:0] s4;
        logic       co, ov, to;
        int         bw, gap, held_bad, done_cnt;
        logic [4:0] exp5;

        tests = 0; fails = 0;
        vecs[0] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h64, 8'h32, 1'b1, 8'h97, 1'b0, 1'b1};

        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
        bus4.start = 1'b0; bus4.a = 4'h0;  bus4.b = 4'h0;  bus4.cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_sum",  {24'd0, bus8.sum},  32'd0);
        check("rst_cout", {31'd0, bus8.cout}, 32'd0);
        check("rst_ovf",  {31'd0, get_ovf8()}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, s8, co, ov, bw, to);
            check($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
            check($sformatf("vec%0d_sum", i), {24'd0, s8}, {24'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_busy_w", i), bw, 32'd8);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'd0, ov}, {31'd0, vecs[i].exp_ovf});
`endif
        end

        // start held high; operands swapped during busy must be ignored until relaunch
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'hAA; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check("b2b_first_timeout", {31'd0, to}, 32'd0);
        check("b2b_first_sum",  {24'd0, bus8.sum},  32'h00);
        check("b2b_first_cout", {31'd0, bus8.cout}, 32'd1);
        gap = 0; held_bad = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (bus8.done) begin to = 1'b0; break; end
            if (bus8.sum !== 8'h00 || bus8.cout !== 1'b1) held_bad++;
        end
        bus8.start = 1'b0;
        check("b2b_second_timeout", {31'd0, to}, 32'd0);
        check("b2b_gap", gap, 32'd10);
        check("b2b_sum_held", held_bad, 32'd0);
        check("b2b_second_sum",  {24'd0, bus8.sum},  32'h46);
        check("b2b_second_cout", {31'd0, bus8.cout}, 32'd0);

        // reset during the fourth shift cycle aborts with no done pulse
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("abort_busy_pre", {31'd0, bus8.busy}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus8.busy}, 32'd0);
        check("abort_done", {31'd0, bus8.done}, 32'd0);
        check("abort_sum",  {24'd0, bus8.sum},  32'd0);
        check("abort_cout", {31'd0, bus8.cout}, 32'd0);
        check("abort_ovf",  {31'd0, get_ovf8()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);

        // WIDTH=4 exhaustive
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    run4(4'(ai), 4'(bi), 1'(ci), s4, co, bw, to);
                    exp5 = 5'(ai + bi + ci);
                    check($sformatf("w4_%0h_%0h_%0d", ai, bi, ci),
                          {26'd0, to, co, s4}, {26'd0, 1'b0, exp5});
                    check($sformatf("w4_busy_%0h_%0h_%0d", ai, bi, ci), bw, 32'd4);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
